// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-by-vector engine.
// Controller state encoding and default matrix dimensions live here too.
package mxv_pkg;

  typedef logic [7:0]  uint8_t;
  typedef logic [15:0] uint16_t;
  localparam int DW_DBL = 16;

  localparam int MXV_M_DEF = 4;
  localparam int MXV_N_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    DRAIN,
    DONE
  } mxv_ctrl_state_e;

  // Address/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mxv_controller_if.sv
// Controller <-> datapath bundle: start/abort in, memory strobes, processor
// clear and result flags out. master = controller side.
interface mxv_controller_if #(
  parameter int M = mxv_pkg::MXV_M_DEF,
  parameter int N = mxv_pkg::MXV_N_DEF
) ();
  import mxv_pkg::*;

  localparam int MAT_AW = clog2_min1(M*N);
  localparam int VEC_AW = clog2_min1(N);
  localparam int ROW_W  = clog2_min1(M);

  logic              start;
  logic              abort;
  logic              rd_en;
  logic [MAT_AW-1:0] mat_addr;
  logic [VEC_AW-1:0] vec_addr;
  logic              proc_clr;
  logic              res_valid;
  logic [ROW_W-1:0]  res_row;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort,
    output rd_en, mat_addr, vec_addr, proc_clr, res_valid, res_row, busy, done
  );

  modport slave (
    output start, abort,
    input  rd_en, mat_addr, vec_addr, proc_clr, res_valid, res_row, busy, done
  );

endinterface

// File: rtl/mxv_addr_gen.sv
// Row/column walker for the MxV pass. The counters always hold the operand
// position currently on the address bus, so addresses hold while idle.
module mxv_addr_gen
  import mxv_pkg::*;
#(
  parameter int M = MXV_M_DEF,
  parameter int N = MXV_N_DEF,
  localparam int MAT_AW = clog2_min1(M*N),
  localparam int VEC_AW = clog2_min1(N),
  localparam int ROW_W  = clog2_min1(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv_col,
  input  logic              adv_row,
  output logic [ROW_W-1:0]  row,
  output logic [MAT_AW-1:0] mat_addr,
  output logic [VEC_AW-1:0] vec_addr,
  output logic              last_col,
  output logic              last_row
);

  logic [ROW_W-1:0]  row_q;
  logic [VEC_AW-1:0] col_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_row) begin
      row_q <= row_q + ROW_W'(1);
      col_q <= '0;
    end else if (adv_col) begin
      col_q <= col_q + VEC_AW'(1);
    end
  end

  assign row      = row_q;
  assign vec_addr = col_q;
  assign mat_addr = MAT_AW'(int'(row_q) * N + int'(col_q));
  assign last_col = (col_q == VEC_AW'(N-1));
  assign last_row = (row_q == ROW_W'(M-1));

endmodule

// File: rtl/mxv_controller.sv
// MxV sequencer: walks rows, clears the MAC between rows, flags row results.
// Optional MXV_CTRL_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module mxv_controller
  import mxv_pkg::*;
#(
  parameter int M = MXV_M_DEF,
  parameter int N = MXV_N_DEF
) (
  input  logic clk,
  input  logic rst,
  mxv_controller_if.master bus
`ifdef MXV_CTRL_PERF_EN
  , output logic [31:0] perf_cycles
`endif
);

  localparam int MAT_AW = clog2_min1(M*N);
  localparam int VEC_AW = clog2_min1(N);
  localparam int ROW_W  = clog2_min1(M);

  mxv_ctrl_state_e   state;
  logic              clr_cnt, adv_col, adv_row, last_col, last_row;
  logic [ROW_W-1:0]  row;
  logic [MAT_AW-1:0] mat_addr;
  logic [VEC_AW-1:0] vec_addr;
  logic              rd_en_q, proc_clr_q, res_valid_q, busy_q, done_q;
  logic [ROW_W-1:0]  res_row_q;
  logic              kill;

  assign kill = bus.abort && (state != IDLE);

  mxv_addr_gen #(.M(M), .N(N)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_cnt),
    .adv_col  (adv_col),
    .adv_row  (adv_row),
    .row      (row),
    .mat_addr (mat_addr),
    .vec_addr (vec_addr),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Counter moves mirror the state transitions taken at the same edge.
  always_comb begin
    clr_cnt = 1'b0;
    adv_col = 1'b0;
    adv_row = 1'b0;
    if (!kill) begin
      case (state)
        IDLE:     clr_cnt = bus.start;
        CLR, ACC: adv_col = !last_col;
        DRAIN:    adv_row = !last_row;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rd_en_q     <= 1'b0;
      proc_clr_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (kill) begin
        state      <= IDLE;
        rd_en_q    <= 1'b0;
        proc_clr_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            proc_clr_q <= 1'b1;
            rd_en_q    <= bus.start;
            busy_q     <= bus.start;
            if (bus.start) state <= CLR;
          end
          CLR, ACC: begin
            proc_clr_q <= 1'b0;
            busy_q     <= 1'b1;
            rd_en_q    <= !last_col;
            state      <= last_col ? DRAIN : ACC;
          end
          // Finished row is on Data_output for exactly the next cycle.
          DRAIN: begin
            proc_clr_q  <= 1'b1;
            busy_q      <= 1'b1;
            res_valid_q <= 1'b1;
            res_row_q   <= row;
            rd_en_q     <= !last_row;
            done_q      <= last_row;
            state       <= last_row ? DONE : CLR;
          end
          default: begin
            state      <= IDLE;
            rd_en_q    <= 1'b0;
            proc_clr_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.mat_addr  = mat_addr;
  assign bus.vec_addr  = vec_addr;
  assign bus.proc_clr  = proc_clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_row   = res_row_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef MXV_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         perf_cycles <= '0;
    else if (state == IDLE && bus.start) perf_cycles <= '0;
    else if (busy_q && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mxv_controller.sv
// Directed bench: three controller configurations, each with operand memories
// and an 8x8->16 MAC model; row results are scored against hand sums.
module tb_mxv_controller;
  import mxv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, s0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mxv_controller_if #(.M(4), .N(4)) ifa ();
  mxv_controller_if #(.M(2), .N(3)) ifb ();
  mxv_controller_if #(.M(3), .N(1)) ifc ();

`ifdef MXV_CTRL_PERF_EN
  logic [31:0] perf_a, perf_b, perf_c;
`endif

  mxv_controller #(.M(4), .N(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa)
`ifdef MXV_CTRL_PERF_EN
    , .perf_cycles(perf_a)
`endif
  );
  mxv_controller #(.M(2), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb)
`ifdef MXV_CTRL_PERF_EN
    , .perf_cycles(perf_b)
`endif
  );
  mxv_controller #(.M(3), .N(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc)
`ifdef MXV_CTRL_PERF_EN
    , .perf_cycles(perf_c)
`endif
  );

  // Memories (1-cycle read) and MAC with synchronous clear.
  uint8_t  mat_a[16], vec_a[4], md_a, vd_a;
  uint8_t  mat_b[8],  vec_b[4], md_b, vd_b;
  uint8_t  mat_c[4],  vec_c[2], md_c, vd_c;
  uint16_t acc_a, acc_b, acc_c;

  always @(posedge clk) begin
    if (ifa.rd_en) begin md_a <= mat_a[ifa.mat_addr]; vd_a <= vec_a[ifa.vec_addr]; end
    if (ifb.rd_en) begin md_b <= mat_b[ifb.mat_addr]; vd_b <= vec_b[ifb.vec_addr]; end
    if (ifc.rd_en) begin md_c <= mat_c[ifc.mat_addr]; vd_c <= vec_c[ifc.vec_addr]; end
    acc_a <= ifa.proc_clr ? 16'd0 : acc_a + 16'(md_a) * 16'(vd_a);
    acc_b <= ifb.proc_clr ? 16'd0 : acc_b + 16'(md_b) * 16'(vd_b);
    acc_c <= ifc.proc_clr ? 16'd0 : acc_c + 16'(md_c) * 16'(vd_c);
  end

  // Result log: row, value and cycle relative to the start edge (1 = first cycle after).
  int q_row[3][$], q_val[3][$], q_cyc[3][$];
  int dn[3] = '{0, 0, 0};
  int dn_cyc[3] = '{0, 0, 0};
  int bad_idle_b = 0, idle_b = 0, acc_c_seen = 0;
  int base[3], dbase[3];

  always @(negedge clk) begin
    if (ifa.res_valid) begin
      q_row[0].push_back(int'(ifa.res_row)); q_val[0].push_back(int'(acc_a)); q_cyc[0].push_back(cyc - s0 + 1);
    end
    if (ifb.res_valid) begin
      q_row[1].push_back(int'(ifb.res_row)); q_val[1].push_back(int'(acc_b)); q_cyc[1].push_back(cyc - s0 + 1);
    end
    if (ifc.res_valid) begin
      q_row[2].push_back(int'(ifc.res_row)); q_val[2].push_back(int'(acc_c)); q_cyc[2].push_back(cyc - s0 + 1);
    end
    if (ifa.done) begin dn[0] <= dn[0] + 1; dn_cyc[0] <= cyc - s0 + 1; end
    if (ifb.done) begin dn[1] <= dn[1] + 1; dn_cyc[1] <= cyc - s0 + 1; end
    if (ifc.done) begin dn[2] <= dn[2] + 1; dn_cyc[2] <= cyc - s0 + 1; end
    if (rst && !ifb.busy) idle_b <= idle_b + 1;
    if (rst && !ifb.busy && !ifb.proc_clr) bad_idle_b <= bad_idle_b + 1;
    if (ifc.rd_en && !ifc.proc_clr) acc_c_seen <= acc_c_seen + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_rd_en"},     int'(ifa.rd_en),     0);
    chk({tag, "_proc_clr"},  int'(ifa.proc_clr),  1);
    chk({tag, "_res_valid"}, int'(ifa.res_valid), 0);
    chk({tag, "_done"},      int'(ifa.done),      0);
    chk({tag, "_busy"},      int'(ifa.busy),      0);
    chk({tag, "_mat_addr"},  int'(ifa.mat_addr),  0);
    chk({tag, "_vec_addr"},  int'(ifa.vec_addr),  0);
  endtask

  task automatic do_start(input int k);
    base[k]  = q_row[k].size();
    dbase[k] = dn[k];
    @(negedge clk);
    case (k)
      0:       ifa.start = 1'b1;
      1:       ifb.start = 1'b1;
      default: ifc.start = 1'b1;
    endcase
    @(posedge clk); #1;
    s0 = cyc;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int i = 0;
    while (dn[k] == dbase[k] && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("done_seen_%0d", k), int'(dn[k] != dbase[k]), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_res(input string tag, input int k, input int n, input int first,
                           input int period, input int v0, input int v1, input int v2, input int v3);
    int vals[4];
    vals = '{v0, v1, v2, v3};
    chk({tag, "_count"}, q_row[k].size() - base[k], n);
    if (q_row[k].size() - base[k] == n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_row%0d_idx", tag, i), q_row[k][base[k]+i], i);
        chk($sformatf("%s_row%0d_val", tag, i), q_val[k][base[k]+i], vals[i]);
        chk($sformatf("%s_row%0d_cyc", tag, i), q_cyc[k][base[k]+i], first + i*period);
      end
    end
  endtask

  initial begin
    ifa.start = 0; ifa.abort = 0;
    ifb.start = 0; ifb.abort = 0;
    ifc.start = 0; ifc.abort = 0;
    for (int i = 0; i < 16; i++) mat_a[i] = 8'd1;
    vec_a = '{8'd1, 8'd2, 8'd3, 8'd4};
    mat_b = '{8'd1, 8'd2, 8'd3, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0};
    vec_b = '{8'd1, 8'd1, 8'd1, 8'd0};
    mat_c = '{8'd2, 8'd3, 8'd4, 8'd0};
    vec_c = '{8'd5, 8'd0};

    repeat (2) @(negedge clk);
    chk_idle_a("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // M=N=4: every row sums to 1+2+3+4.
    do_start(0);
    wait_done(0, 60);
    check_res("a4x4", 0, 4, 6, 5, 10, 10, 10, 10);
    chk("a4x4_done_cyc", dn_cyc[0], 21);
`ifdef MXV_CTRL_PERF_EN
    chk("perf_after_done", int'(perf_a), 21);
    repeat (3) @(negedge clk);
    chk("perf_hold", int'(perf_a), 21);
`endif

    // M=2,N=3: includes a 255*1*3 row.
    do_start(1);
    wait_done(1, 60);
    check_res("b2x3", 1, 2, 5, 4, 6, 765, 0, 0);
    chk("b2x3_done_cyc", dn_cyc[1], 9);
    chk("b_idle_seen", int'(idle_b > 0), 1);
    chk("b_idle_clr", bad_idle_b, 0);

    // N=1: CLR straight to DRAIN, 2-cycle row period.
    do_start(2);
    wait_done(2, 60);
    check_res("c3x1", 2, 3, 3, 2, 10, 15, 20, 0);
    chk("c3x1_done_cyc", dn_cyc[2], 7);
    chk("c_no_acc", acc_c_seen, 0);

    // Abort during ACC of row 1 (cycle 7).
    do_start(0);
    repeat (7) @(negedge clk);
    chk("abort_pre_busy", int'(ifa.busy), 1);
    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    chk("abort_busy", int'(ifa.busy), 0);
    chk("abort_rd_en", int'(ifa.rd_en), 0);
    chk("abort_proc_clr", int'(ifa.proc_clr), 1);
    repeat (30) @(negedge clk);
    chk("abort_results", q_row[0].size() - base[0], 1);
    chk("abort_no_done", dn[0] - dbase[0], 0);
`ifdef MXV_CTRL_PERF_EN
    chk("perf_abort_hold", int'(perf_a), 7);
`endif

    // Fresh pass after abort.
    do_start(0);
`ifdef MXV_CTRL_PERF_EN
    @(negedge clk);
    chk("perf_restart_clear", int'(perf_a), 0);
`endif
    wait_done(0, 60);
    check_res("a_after_abort", 0, 4, 6, 5, 10, 10, 10, 10);

    // Async reset in ACC of row 0; the pass must not resume.
    do_start(0);
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", int'(ifa.busy), 1);
    rst = 1'b0;
    #1;
    chk_idle_a("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_done", dn[0] - dbase[0], 0);
    chk("midrst_no_result", q_row[0].size() - base[0], 0);

    // Second start while busy is ignored.
    do_start(0);
    repeat (3) @(negedge clk);
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    wait_done(0, 60);
    check_res("a_busy_start", 0, 4, 6, 5, 10, 10, 10, 10);
    chk("busy_start_done_cyc", dn_cyc[0], 21);
    repeat (30) @(negedge clk);
    chk("busy_start_one_done", dn[0] - dbase[0], 1);
    chk("busy_start_idle", int'(ifa.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
